// File: rtl/page_pool_pkg.sv
// page_pool_pkg: default widths, page/tag/entry types and request FSM encodings
// shared by the page_pool front end and its FIFO.
package page_pool_pkg;
   localparam int PP_PAGE_W = 15;
   localparam int PP_WHO_W  = 4;

   typedef logic [PP_PAGE_W-1:0] page_t;
   typedef logic [PP_WHO_W-1:0]  who_t;

   typedef struct packed {
      page_t page;
      who_t  who;
   } free_ent_t;

   typedef enum logic [0:0] {
      A_IDLE = 1'b0,
      A_WAIT = 1'b1
   } alloc_state_e;

   typedef enum logic [0:0] {
      F_IDLE = 1'b0,
      F_WAIT = 1'b1
   } free_state_e;
endpackage

// File: rtl/page_pool_fifo.sv
// page_pool_fifo: synchronous FIFO with two ordered write ports (a lands before b),
// one read port, and current/next occupancy outputs.
module page_pool_fifo #(
   parameter  int W     = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          push_a_i,
   input  logic [W-1:0]  din_a_i,
   input  logic          push_b_i,
   input  logic [W-1:0]  din_b_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic [LW-1:0] level_o,
   output logic [LW-1:0] level_next_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, wr_b_s;
   logic [LW-1:0] cnt_q, cnt_d;

   // Pointer and occupancy arithmetic; port b writes the slot after port a.
   always_comb begin
      wr_b_s = wr_q + AW'(push_a_i);
      wr_d   = wr_b_s + AW'(push_b_i);
      rd_d   = rd_q + AW'(pop_i);
      cnt_d  = cnt_q + LW'(push_a_i) + LW'(push_b_i) - LW'(pop_i);
   end

   // Storage and pointers; storage is cleared so the head reads zero after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {W{1'b0}};
         end
         wr_q  <= {AW{1'b0}};
         rd_q  <= {AW{1'b0}};
         cnt_q <= {LW{1'b0}};
      end else begin
         if (push_a_i) begin
            mem_q[wr_q] <= din_a_i;
         end
         if (push_b_i) begin
            mem_q[wr_b_s] <= din_b_i;
         end
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Head and level views of the registered state.
   always_comb begin
      dout_o       = mem_q[rd_q];
      level_o      = cnt_q;
      level_next_o = cnt_d;
   end
endmodule

// File: rtl/page_pool.sv
// page_pool: prefetch pool of allocated pages plus tagged free queue in front of the
// page allocator. Optional macro PAGE_POOL_RECYCLE_EN routes frees straight into the pool.
module page_pool
   import page_pool_pkg::*;
#(
   parameter  int PAGE_W = PP_PAGE_W,
   parameter  int WHO_W  = PP_WHO_W,
   parameter  int DEPTH  = 4,
   parameter  int FDEPTH = 8,
   localparam int PLW    = $clog2(DEPTH) + 1,
   localparam int FLW    = $clog2(FDEPTH) + 1
)(
   input  logic              clk,
   input  logic              reset,
   output logic              get_valid,
   input  logic              get_ready,
   output logic [PAGE_W-1:0] get_page,
   input  logic              put_valid,
   output logic              put_ready,
   input  logic [PAGE_W-1:0] put_page,
   input  logic [WHO_W-1:0]  put_who,
   output logic              alloc_req,
   input  logic              alloc_gnt,
   input  logic [PAGE_W-1:0] alloc_page,
   output logic              free_req,
   input  logic              free_gnt,
   output logic [PAGE_W-1:0] free_page,
   output logic [WHO_W-1:0]  free_who,
   output logic [PLW-1:0]    pool_level,
   output logic [FLW-1:0]    free_level
);
   localparam int             EW        = PAGE_W + WHO_W;
   localparam logic [PLW-1:0] POOL_FULL = PLW'(DEPTH);
   localparam logic [FLW-1:0] FQ_FULL   = FLW'(FDEPTH);

   alloc_state_e    a_state_q, a_state_d;
   free_state_e     f_state_q, f_state_d;
   logic            put_ready_q;
   logic            put_acc_s, recycle_s, pool_push_s, pool_pop_s, fq_push_s, fq_pop_s;
   logic [PLW-1:0]  pool_level_s, pool_level_next_s;
   logic [FLW-1:0]  free_level_s, free_level_next_s;
   logic [PAGE_W-1:0] pool_head_s;
   logic [EW-1:0]   fq_head_s;

   // FIFO handshakes; grants are only honoured while the matching request is pending.
   always_comb begin
      put_acc_s   = put_valid & put_ready_q;
`ifdef PAGE_POOL_RECYCLE_EN
      // Reserve a slot for an outstanding alloc so a same-cycle grant cannot overflow.
      recycle_s   = put_acc_s & ((pool_level_s + PLW'(alloc_req)) < POOL_FULL);
`else
      recycle_s   = 1'b0;
`endif
      pool_push_s = alloc_gnt & (a_state_q == A_WAIT);
      pool_pop_s  = get_valid & get_ready;
      fq_push_s   = put_acc_s & ~recycle_s;
      fq_pop_s    = free_gnt & (f_state_q == F_WAIT);
   end

   page_pool_fifo #(.W(PAGE_W), .DEPTH(DEPTH)) u_pool (
      .clk          (clk),
      .reset        (reset),
      .push_a_i     (pool_push_s),
      .din_a_i      (alloc_page),
      .push_b_i     (recycle_s),
      .din_b_i      (put_page),
      .pop_i        (pool_pop_s),
      .dout_o       (pool_head_s),
      .level_o      (pool_level_s),
      .level_next_o (pool_level_next_s)
   );

   page_pool_fifo #(.W(EW), .DEPTH(FDEPTH)) u_freeq (
      .clk          (clk),
      .reset        (reset),
      .push_a_i     (fq_push_s),
      .din_a_i      ({put_page, put_who}),
      .push_b_i     (1'b0),
      .din_b_i      ({EW{1'b0}}),
      .pop_i        (fq_pop_s),
      .dout_o       (fq_head_s),
      .level_o      (free_level_s),
      .level_next_o (free_level_next_s)
   );

   // Request FSM state and the registered free-queue ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_state_q   <= A_IDLE;
         f_state_q   <= F_IDLE;
         put_ready_q <= 1'b0;
      end else begin
         a_state_q   <= a_state_d;
         f_state_q   <= f_state_d;
         put_ready_q <= (free_level_next_s < FQ_FULL);
      end
   end

   // Next state: alloc looks at post-edge pool level so a pop re-requests immediately.
   always_comb begin
      case (a_state_q)
         A_IDLE:  a_state_d = (pool_level_next_s < POOL_FULL) ? A_WAIT : A_IDLE;
         A_WAIT:  a_state_d = alloc_gnt ? A_IDLE : A_WAIT;
         default: a_state_d = A_IDLE;
      endcase
      case (f_state_q)
         F_IDLE:  f_state_d = (free_level_s != {FLW{1'b0}}) ? F_WAIT : F_IDLE;
         F_WAIT:  f_state_d = free_gnt ? F_IDLE : F_WAIT;
         default: f_state_d = F_IDLE;
      endcase
   end

   // Outputs decoded purely from registered state.
   always_comb begin
      alloc_req  = (a_state_q == A_WAIT);
      free_req   = (f_state_q == F_WAIT);
      get_valid  = (pool_level_s != {PLW{1'b0}});
      put_ready  = put_ready_q;
      get_page   = pool_head_s;
      free_page  = fq_head_s[EW-1:WHO_W];
      free_who   = fq_head_s[WHO_W-1:0];
      pool_level = pool_level_s;
      free_level = free_level_s;
   end
endmodule
